// File: rtl/video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// video_mode_sequencer
//
// Sequences a change of video mode for a video generator that is driven by a
// reconfigurable pixel PLL. A request is accepted in IDLE, then:
//   WAIT_VS      wait for the vsync active edge so the switch lands on a frame
//                boundary (skipped when the generator is not running)
//   HOLD         hold the generator in reset and switch the config mux
//   PLL_CFG      one-cycle reconfiguration pulse to the PLL
//   WAIT_LOCK    wait for the PLL to relock, then release the generator
//   WAIT_RESTART wait for the generator's restart pulse
//   WAIT_FC      wait for the generator to complete a full vsync cycle
// Every wait state is guarded by a timeout that returns to IDLE with the
// generator out of reset and a sticky error flag raised.
// After reset the block starts in HOLD, so power-on runs the full bring-up
// sequence for INIT_MODE without any request.
//
// Parameters
//   INIT_MODE       mode loaded at reset
//   HOLD_CYCLES     number of cycles the video reset is held in HOLD
//   TIMEOUT_CYCLES  per-wait-state timeout limit (fits the 23-bit counter)
//
// Ports
//   clock             sole clock, rising edge
//   reset             synchronous, active-high reset
//   req_valid         mode-change request
//   req_mode[3:0]     requested mode index
//   req_ready         high in IDLE; request taken when req_valid & req_ready
//   vsync             vsync from the video generator
//   vsync_on_polarity active level of vsync
//   pll_locked        pixel PLL lock status
//   restart           one-cycle pulse from the generator on trigger start
//   fullcycle         generator has completed one vsync
//   video_reset_n     active-low reset to the generator (registered)
//   pll_reconfig      one-cycle PLL reconfiguration pulse (registered)
//   active_mode[3:0]  config-select index for the video config mux
//   busy              high in every state except IDLE
//   timeout_err       sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module video_mode_sequencer #(
  parameter logic [3:0]  INIT_MODE      = 4'd0,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_mode,
  output logic       req_ready,
  input  logic       vsync,
  input  logic       vsync_on_polarity,
  input  logic       pll_locked,
  input  logic       restart,
  input  logic       fullcycle,
  output logic       video_reset_n,
  output logic       pll_reconfig,
  output logic [3:0] active_mode,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    HOLD,
    PLL_CFG,
    WAIT_LOCK,
    WAIT_RESTART,
    WAIT_FC
  } state_t;

  localparam logic [22:0] TMO_LAST  = 23'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  // Lock status is not trusted during the two cycles after the reconfig
  // pulse is issued: the PLL_CFG cycle and the WAIT_LOCK entry cycle.
  localparam logic [22:0] LOCK_MASK = 23'd1;

  state_t      state_q,         state_d;
  logic [3:0]  pending_mode_q,  pending_mode_d;
  logic [3:0]  active_mode_q,   active_mode_d;
  logic        video_reset_n_q, video_reset_n_d;
  logic        pll_reconfig_q,  pll_reconfig_d;
  logic        req_ready_q,     req_ready_d;
  logic        busy_q,          busy_d;
  logic        timeout_err_q,   timeout_err_d;
  logic [31:0] hold_cnt_q,      hold_cnt_d;
  logic [22:0] tmo_cnt_q,       tmo_cnt_d;
  logic        vs_act_q,        vs_act_d;
  logic        vs_prev_q,       vs_prev_d;

  logic        in_wait;
  logic        vs_rise;

  assign in_wait = (state_q == WAIT_VS)      || (state_q == WAIT_LOCK) ||
                   (state_q == WAIT_RESTART) || (state_q == WAIT_FC);

  // vsync is sampled once; the edge is seen between the sample and its
  // delayed copy, so the state leaves WAIT_VS one cycle after the sample.
  assign vs_rise = vs_act_q & ~vs_prev_q;

  always_comb begin
    state_d         = state_q;
    pending_mode_d  = pending_mode_q;
    active_mode_d   = active_mode_q;
    video_reset_n_d = video_reset_n_q;
    timeout_err_d   = timeout_err_q;
    hold_cnt_d      = hold_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    vs_act_d        = (vsync == vsync_on_polarity);
    vs_prev_d       = vs_act_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          pending_mode_d = req_mode;
          // Re-requesting the running mode of a running generator is a no-op.
          if (!((req_mode == active_mode_q) && fullcycle)) begin
            state_d = WAIT_VS;
          end
        end
      end
      WAIT_VS: begin
        // A stopped generator produces no vsync; switch straight away.
        if (!fullcycle || vs_rise) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = PLL_CFG;
        end
      end
      PLL_CFG: begin
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if ((tmo_cnt_q >= LOCK_MASK) && pll_locked) begin
          state_d         = WAIT_RESTART;
          video_reset_n_d = 1'b1;
        end
      end
      WAIT_RESTART: begin
        // fullcycle is deliberately not looked at here: a coincident
        // restart and fullcycle only advances to WAIT_FC.
        if (restart) begin
          state_d = WAIT_FC;
        end
      end
      WAIT_FC: begin
        if (fullcycle) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout overrides any transition chosen above.
    if (in_wait && (tmo_cnt_q == TMO_LAST)) begin
      state_d         = IDLE;
      timeout_err_d   = 1'b1;
      video_reset_n_d = 1'b1;
    end

    // HOLD entry: generator into reset and config mux switched together.
    if ((state_d == HOLD) && (state_q != HOLD)) begin
      video_reset_n_d = 1'b0;
      active_mode_d   = pending_mode_q;
    end

    // Counters restart on every state change.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      tmo_cnt_d  = '0;
    end else begin
      if (state_q == HOLD) begin
        hold_cnt_d = hold_cnt_q + 32'd1;
      end
      if (in_wait && (tmo_cnt_q != '1)) begin
        tmo_cnt_d = tmo_cnt_q + 23'd1;
      end
    end

    // Status outputs are registered copies of the next state.
    pll_reconfig_d = (state_d == PLL_CFG);
    req_ready_d    = (state_d == IDLE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= HOLD;
      pending_mode_q  <= INIT_MODE;
      active_mode_q   <= INIT_MODE;
      video_reset_n_q <= 1'b0;
      pll_reconfig_q  <= 1'b0;
      req_ready_q     <= 1'b0;
      busy_q          <= 1'b1;
      timeout_err_q   <= 1'b0;
      hold_cnt_q      <= '0;
      tmo_cnt_q       <= '0;
      vs_act_q        <= 1'b0;
      vs_prev_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_mode_q  <= pending_mode_d;
      active_mode_q   <= active_mode_d;
      video_reset_n_q <= video_reset_n_d;
      pll_reconfig_q  <= pll_reconfig_d;
      req_ready_q     <= req_ready_d;
      busy_q          <= busy_d;
      timeout_err_q   <= timeout_err_d;
      hold_cnt_q      <= hold_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      vs_act_q        <= vs_act_d;
      vs_prev_q       <= vs_prev_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign video_reset_n = video_reset_n_q;
  assign pll_reconfig  = pll_reconfig_q;
  assign active_mode   = active_mode_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_video_mode_sequencer
//
// Directed bench for video_mode_sequencer (HOLD_CYCLES=16, TIMEOUT_CYCLES=64).
// A hand-written power-on sequence is followed by a table of input records,
// each applied for a number of clock edges and then compared against the
// hand-computed output word {video_reset_n, pll_reconfig, req_ready, busy,
// active_mode[3:0], timeout_err}.
// -----------------------------------------------------------------------------
module tb_video_mode_sequencer;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_mode;
  logic       req_ready;
  logic       vsync;
  logic       vsync_on_polarity;
  logic       pll_locked;
  logic       restart;
  logic       fullcycle;
  logic       video_reset_n;
  logic       pll_reconfig;
  logic [3:0] active_mode;
  logic       busy;
  logic       timeout_err;

  video_mode_sequencer #(
    .INIT_MODE      (4'd0),
    .HOLD_CYCLES    (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_mode          (req_mode),
    .req_ready         (req_ready),
    .vsync             (vsync),
    .vsync_on_polarity (vsync_on_polarity),
    .pll_locked        (pll_locked),
    .restart           (restart),
    .fullcycle         (fullcycle),
    .video_reset_n     (video_reset_n),
    .pll_reconfig      (pll_reconfig),
    .active_mode       (active_mode),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int unsigned cycles;
    logic        rst;
    logic        pol;
    logic        rv;
    logic [3:0]  rm;
    logic        vs;
    logic        lk;
    logic        rs;
    logic        fc;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic add(input string name, input int unsigned cycles, input logic rst,
                     input logic pol, input logic rv, input logic [3:0] rm, input logic vs,
                     input logic lk, input logic rs, input logic fc,
                     input logic e_vrn, input logic e_cfg, input logic e_rdy,
                     input logic e_busy, input logic [3:0] e_mode, input logic e_err);
    vec_t v;
    v.name = name; v.cycles = cycles; v.rst = rst; v.pol = pol; v.rv = rv; v.rm = rm;
    v.vs = vs; v.lk = lk; v.rs = rs; v.fc = fc;
    v.exp = {e_vrn, e_cfg, e_rdy, e_busy, e_mode, e_err};
    vecs.push_back(v);
  endtask

  initial begin
    int low;
    int pulses;
    int n;
    logic [8:0] got;

    // name, cycles, rst pol rv rm vs lk rs fc | vrn cfg rdy busy mode err
    add("same_mode_accept",   1, 0,1,1,4'd0,0,1,0,1, 1,0,1,0,4'd0,0);
    add("same_mode_quiet",    3, 0,1,0,4'd0,0,1,0,1, 1,0,1,0,4'd0,0);
    add("req3_accept",        1, 0,1,1,4'd3,0,1,0,1, 1,0,0,1,4'd0,0);
    add("wait_vs_no_edge",    5, 0,1,0,4'd3,0,1,0,1, 1,0,0,1,4'd0,0);
    add("vs_edge_sampled",    1, 0,1,0,4'd3,1,1,0,1, 1,0,0,1,4'd0,0);
    add("hold_entry_mode3",   1, 0,1,0,4'd3,1,1,0,1, 0,0,0,1,4'd3,0);
    add("hold_req_ignored",  15, 0,1,1,4'd7,1,1,0,1, 0,0,0,1,4'd3,0);
    add("pll_cfg_pulse",      1, 0,1,1,4'd7,1,1,0,1, 0,1,0,1,4'd3,0);
    add("lock_masked",        2, 0,1,1,4'd7,1,1,0,1, 0,0,0,1,4'd3,0);
    add("lock_taken",         1, 0,1,1,4'd7,1,1,0,1, 1,0,0,1,4'd3,0);
    add("fc_ignored_wrst",    3, 0,1,1,4'd7,1,1,0,1, 1,0,0,1,4'd3,0);
    add("restart_with_fc",    1, 0,1,1,4'd7,1,1,1,1, 1,0,0,1,4'd3,0);
    add("fc_to_idle",         1, 0,1,1,4'd7,1,1,0,1, 1,0,1,0,4'd3,0);
    add("held_req_accepted",  1, 0,1,1,4'd7,1,1,0,1, 1,0,0,1,4'd3,0);
    add("fc0_skips_vsync",    1, 0,1,0,4'd7,1,1,0,0, 0,0,0,1,4'd7,0);
    add("hold_mode7",        15, 0,1,0,4'd7,1,1,0,0, 0,0,0,1,4'd7,0);
    add("pll_cfg_mode7",      1, 0,1,0,4'd7,1,0,0,0, 0,1,0,1,4'd7,0);
    add("wl_unlocked_entry",  1, 0,1,0,4'd7,1,0,0,0, 0,0,0,1,4'd7,0);
    add("wl_unlocked_62",    62, 0,1,0,4'd7,1,0,0,0, 0,0,0,1,4'd7,0);
    add("wl_last_cycle",      1, 0,1,0,4'd7,1,0,0,0, 0,0,0,1,4'd7,0);
    add("wl_timeout",         1, 0,1,0,4'd7,1,0,0,0, 1,0,1,0,4'd7,1);
    add("err_sticky",         3, 0,1,1,4'd7,1,1,0,1, 1,0,1,0,4'd7,1);
    add("req5_accept",        1, 0,1,1,4'd5,0,1,0,1, 1,0,0,1,4'd7,1);
    add("req5_hold",          1, 0,1,0,4'd5,0,1,0,0, 0,0,0,1,4'd5,1);
    add("req5_hold_rest",    15, 0,1,0,4'd5,0,1,0,0, 0,0,0,1,4'd5,1);
    add("req5_cfg",           1, 0,1,0,4'd5,0,1,0,0, 0,1,0,1,4'd5,1);
    add("req5_wait_restart",  3, 0,1,0,4'd5,0,1,0,0, 1,0,0,1,4'd5,1);
    add("reset_mid_seq",      1, 1,1,0,4'd0,0,1,0,0, 0,0,0,1,4'd0,0);
    add("post_reset_hold16", 16, 0,1,0,4'd0,0,1,0,0, 0,1,0,1,4'd0,0);
    add("post_reset_lock",    3, 0,1,0,4'd0,0,1,0,0, 1,0,0,1,4'd0,0);
    add("post_reset_restart", 1, 0,1,0,4'd0,0,1,1,1, 1,0,0,1,4'd0,0);
    add("post_reset_idle",    1, 0,1,0,4'd0,0,1,0,1, 1,0,1,0,4'd0,0);
    add("pol0_req2",          1, 0,0,1,4'd2,1,1,0,1, 1,0,0,1,4'd0,0);
    add("pol0_inactive",      3, 0,0,0,4'd2,1,1,0,1, 1,0,0,1,4'd0,0);
    add("pol0_edge_sampled",  1, 0,0,0,4'd2,0,1,0,1, 1,0,0,1,4'd0,0);
    add("pol0_hold_mode2",    1, 0,0,0,4'd2,0,1,0,1, 0,0,0,1,4'd2,0);

    // Power-on: reset held, then the automatic bring-up of INIT_MODE.
    reset = 1'b1; req_valid = 1'b0; req_mode = 4'd0; vsync = 1'b0;
    vsync_on_polarity = 1'b1; pll_locked = 1'b1; restart = 1'b0; fullcycle = 1'b0;
    repeat (3) step();
    check("rst_video_reset_n", 32'(video_reset_n), 32'd0);
    check("rst_pll_reconfig",  32'(pll_reconfig),  32'd0);
    check("rst_req_ready",     32'(req_ready),     32'd0);
    check("rst_busy",          32'(busy),          32'd1);
    check("rst_timeout_err",   32'(timeout_err),   32'd0);
    check("rst_active_mode",   32'(active_mode),   32'd0);

    reset = 1'b0;
    low = 1; pulses = 0; n = 0;
    while (video_reset_n == 1'b0 && n < 60) begin
      step();
      n++;
      if (!video_reset_n) low++;
      if (pll_reconfig) pulses++;
    end
    check("por_reset_low_cycles", 32'(low), 32'd19);
    check("por_reconfig_pulses",  32'(pulses), 32'd1);
    check("por_wait_restart_rdy", 32'(req_ready), 32'd0);

    restart = 1'b1;
    step();
    restart = 1'b0;
    check("por_wait_fc_busy", 32'(busy), 32'd1);
    fullcycle = 1'b1;
    step();
    check("por_idle_ready", 32'(req_ready), 32'd1);
    check("por_idle_busy",  32'(busy), 32'd0);
    check("por_idle_mode",  32'(active_mode), 32'd0);

    // Table-driven section.
    foreach (vecs[i]) begin
      reset = vecs[i].rst; vsync_on_polarity = vecs[i].pol; req_valid = vecs[i].rv;
      req_mode = vecs[i].rm; vsync = vecs[i].vs; pll_locked = vecs[i].lk;
      restart = vecs[i].rs; fullcycle = vecs[i].fc;
      repeat (vecs[i].cycles) step();
      got = {video_reset_n, pll_reconfig, req_ready, busy, active_mode, timeout_err};
      check(vecs[i].name, 32'(got), 32'(vecs[i].exp));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
